// File: rtl/spi_tx_arbiter_if.sv
// Bundle of requester-side and spi_slave-side signals around spi_tx_arbiter.
// The arbiter connects through the slave modport; the environment drives the master modport.
interface spi_tx_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 24
);
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        ack;
  logic [N-1:0]        grant;
  logic                wr_buffer_free;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                timeout_evt;

  modport master (
    output req, req_data, req_last, wr_buffer_free,
    input  ack, grant, wr_en, wr_data, timeout_evt
  );

  modport slave (
    input  req, req_data, req_last, wr_buffer_free,
    output ack, grant, wr_en, wr_data, timeout_evt
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin, burst-locking arbiter sharing one spi_slave transmit path among N requesters.
// Define SPI_TX_ARB_FIXED_PRIO_EN to pin the search start to requester 0 (fixed priority).
module spi_tx_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  spi_tx_arbiter_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N);
  localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e              state_q,   state_d;
  logic [IDX_W-1:0]    owner_q,   owner_d;
  logic [IDX_W-1:0]    rr_q,      rr_d;
  logic [15:0]         stall_q,   stall_d;
  logic                holdoff_q, holdoff_d;
  logic [N-1:0]        grant_q,   grant_d;
  logic [N-1:0]        ack_q,     ack_d;
  logic                wr_en_q,   wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                tevt_q,    tevt_d;

  logic                hit_s;
  logic [IDX_W-1:0]    hit_idx_s;
  logic                own_req_s;
  logic                own_last_s;
  logic [DATA_W-1:0]   own_data_s;
  logic                push_s;
  logic [15:0]         stall_next_s;
  logic                expire_s;
  logic                release_s;
  logic [IDX_W-1:0]    rr_adv_s;

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  // Circular search for the first pending request, starting at the rr pointer.
  always_comb begin
    logic [IDX_W:0] cand;
    hit_s     = 1'b0;
    hit_idx_s = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end else begin
        cand = cand;
      end
      if (!hit_s && bus.req[cand[IDX_W-1:0]]) begin
        hit_s     = 1'b1;
        hit_idx_s = cand[IDX_W-1:0];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Owner's request, last flag and word, selected by the registered owner index.
  always_comb begin
    own_req_s  = 1'b0;
    own_last_s = 1'b0;
    own_data_s = '0;
    for (int i = 0; i < N; i++) begin
      own_req_s  = own_req_s  | (bus.req[i]      & (owner_q == IDX_W'(i)));
      own_last_s = own_last_s | (bus.req_last[i] & (owner_q == IDX_W'(i)));
      own_data_s = own_data_s | (bus.req_data[i*DATA_W +: DATA_W]
                                 & {DATA_W{owner_q == IDX_W'(i)}});
    end
  end

  // Holdoff forces an idle cycle after each push so spi_slave can drop wr_buffer_free.
  assign push_s       = (state_q == ST_OWN) && own_req_s && bus.wr_buffer_free && !holdoff_q;
  assign stall_next_s = stall_q + 16'd1;
  assign expire_s     = (state_q == ST_OWN) && !own_req_s && (stall_next_s == TIMEOUT_C);
  assign release_s    = (push_s && own_last_s) || expire_s;
  assign rr_adv_s     = (owner_q == LAST_IDX) ? {IDX_W{1'b0}} : (owner_q + IDX_W'(1));

  // State register: every flop, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      stall_q   <= 16'd0;
      holdoff_q <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      tevt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      stall_q   <= stall_d;
      holdoff_q <= holdoff_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      tevt_q    <= tevt_d;
    end
  end

  // Next-state logic: ownership, rr pointer, stall counter and holdoff.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    stall_d   = stall_q;
    holdoff_d = push_s;
    case (state_q)
      ST_IDLE: begin
        stall_d = 16'd0;
        if (hit_s) begin
          state_d = ST_OWN;
          owner_d = hit_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          state_d = ST_IDLE;
          rr_d    = rr_adv_s;
          stall_d = 16'd0;
        end else if (push_s) begin
          stall_d = 16'd0;
        end else if (!own_req_s) begin
          stall_d = stall_next_s;
        end else begin
          stall_d = stall_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 16'd0;
      end
    endcase
`ifdef SPI_TX_ARB_FIXED_PRIO_EN
    rr_d = '0;
`else
    rr_d = rr_d;
`endif
  end

  // Output logic: next values of the registered grant/ack/push/timeout outputs.
  always_comb begin
    grant_d   = grant_q;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    tevt_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          grant_d = idx_to_onehot(hit_idx_s);
        end else begin
          grant_d = '0;
        end
      end
      ST_OWN: begin
        if (push_s) begin
          wr_en_d   = 1'b1;
          wr_data_d = own_data_s;
          ack_d     = idx_to_onehot(owner_q);
        end else begin
          wr_en_d   = 1'b0;
        end
        if (release_s) begin
          grant_d = '0;
        end else begin
          grant_d = grant_q;
        end
        tevt_d = expire_s;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.timeout_evt = tevt_q;

endmodule
